// File: rtl/argmax_stage.sv
// Streaming argmax: groups every N signed beats into a vector and emits index/value of its maximum.
// Latency: result valid on the edge that accepts the last element; input stalls only on last element vs. pending result.
module argmax_stage #(
  parameter int T    = 16,
  parameter int N    = 4,
  parameter int IDXW = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic signed [T-1:0]    data_in,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [IDXW-1:0]        idx_out,
  output logic signed [T-1:0]    max_out
);

  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

  logic [IDXW-1:0]     count_q,   count_d;
  logic signed [T-1:0] run_max_q, run_max_d;
  logic [IDXW-1:0]     run_idx_q, run_idx_d;
  logic [IDXW-1:0]     idx_q,     idx_d;
  logic signed [T-1:0] max_q,     max_d;
  logic                m_valid_q, m_valid_d;

  logic beat_acc;
  logic res_acc;
  logic is_last;
  logic gt;

  assign is_last = (count_q == LAST);
  // Only a finishing beat needs the result register, so it alone waits on m_ready.
  assign s_ready  = reset && !(is_last && m_valid_q && !m_ready);
  assign beat_acc = s_valid && s_ready;
  assign res_acc  = m_valid_q && m_ready;
  assign gt       = (data_in > run_max_q);

  always_comb begin
    count_d   = count_q;
    run_max_d = run_max_q;
    run_idx_d = run_idx_q;
    idx_d     = idx_q;
    max_d     = max_q;
    m_valid_d = m_valid_q;

    if (res_acc) begin
      m_valid_d = 1'b0;
    end

    if (beat_acc) begin
      if (count_q == '0) begin
        run_max_d = data_in;
        run_idx_d = '0;
        count_d   = IDXW'(1);
      end else if (!is_last) begin
        if (gt) begin
          run_max_d = data_in;
          run_idx_d = count_q;
        end
        count_d = count_q + IDXW'(1);
      end else begin
        // Strict compare keeps the earlier index on ties.
        idx_d     = gt ? LAST : run_idx_q;
        max_d     = gt ? data_in : run_max_q;
        m_valid_d = 1'b1;
        count_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q   <= '0;
      run_max_q <= '0;
      run_idx_q <= '0;
      idx_q     <= '0;
      max_q     <= '0;
      m_valid_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      run_max_q <= run_max_d;
      run_idx_q <= run_idx_d;
      idx_q     <= idx_d;
      max_q     <= max_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign m_valid = m_valid_q;
  assign idx_out = idx_q;
  assign max_out = max_q;

endmodule

// File: tb/tb_argmax_stage.sv
// Directed bench for argmax_stage: inputs driven and outputs sampled on the falling clock edge.
module tb_argmax_stage;

  logic               clk = 1'b0;
  logic               reset;
  logic               s_valid;
  logic               s_ready;
  logic signed [15:0] data_in;
  logic               m_valid;
  logic               m_ready;
  logic [1:0]         idx_out;
  logic signed [15:0] max_out;

  int total = 0;
  int bad   = 0;

  argmax_stage #(.T(16), .N(4), .IDXW(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .data_in (data_in),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .idx_out (idx_out),
    .max_out (max_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic signed [15:0] v);
    s_valid = 1'b1;
    data_in = v;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic idle(input logic rdy);
    s_valid = 1'b0;
    m_ready = rdy;
    data_in = 16'sd99;
    @(negedge clk);
  endtask

  initial begin
    reset   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    data_in = '0;

    // Reset state
    @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_idx", idx_out, 0);
    chk("rst_max", max_out, 0);
    reset   = 1'b1;
    m_ready = 1'b1;
    #1 chk("rel_s_ready", s_ready, 1);
    @(negedge clk);

    // Basic vector
    beat(16'sd2); beat(16'sd0); beat(16'sd67);
    chk("basic_nv_early", m_valid, 0);
    beat(16'sd15);
    chk("basic_vld", m_valid, 1);
    chk("basic_idx", idx_out, 2);
    chk("basic_max", max_out, 67);
    idle(1'b1);
    chk("basic_drop", m_valid, 0);

    // Ties, back-to-back
    beat(16'sd0); beat(16'sd0); beat(16'sd0); beat(16'sd0);
    chk("tie0_vld", m_valid, 1);
    chk("tie0_idx", idx_out, 0);
    chk("tie0_max", max_out, 0);
    beat(16'sd5); beat(16'sd9); beat(16'sd9); beat(16'sd1);
    chk("tie9_vld", m_valid, 1);
    chk("tie9_idx", idx_out, 1);
    chk("tie9_max", max_out, 9);

    // Signed extremes
    beat(-16'sd32768); beat(-16'sd1); beat(-16'sd5); beat(-16'sd2);
    chk("neg_idx", idx_out, 1);
    chk("neg_max", max_out, -1);
    beat(16'sd1); beat(16'sd32767); beat(-16'sd32768); beat(16'sd32767);
    chk("ext_idx", idx_out, 1);
    chk("ext_max", max_out, 32767);
    idle(1'b1);
    chk("ext_drop", m_valid, 0);

    // Backpressure
    m_ready = 1'b0;
    beat(16'sd3); beat(16'sd8); beat(16'sd1); beat(16'sd4);
    chk("bp1_vld", m_valid, 1);
    chk("bp1_idx", idx_out, 1);
    chk("bp1_max", max_out, 8);
    beat(16'sd7); beat(16'sd2); beat(16'sd2);
    chk("bp1_hold_idx", idx_out, 1);
    chk("bp1_hold_max", max_out, 8);
    s_valid = 1'b1;
    data_in = 16'sd2;
    #1 chk("bp_stall_rdy", s_ready, 0);
    @(negedge clk);
    chk("bp_stall_vld", m_valid, 1);
    chk("bp_stall_idx", idx_out, 1);
    chk("bp_stall_max", max_out, 8);
    m_ready = 1'b1;
    #1 chk("bp_release_rdy", s_ready, 1);
    @(negedge clk);
    s_valid = 1'b0;
    chk("bp2_vld", m_valid, 1);
    chk("bp2_idx", idx_out, 0);
    chk("bp2_max", max_out, 7);
    idle(1'b1);
    chk("bp2_drop", m_valid, 0);

    // Gapped input: s_valid 1,0,0,1,0,1,1
    beat(16'sd10); idle(1'b1); idle(1'b1); beat(16'sd20); idle(1'b1); beat(16'sd30);
    chk("gap_nv_early", m_valid, 0);
    m_ready = 1'b0;
    beat(16'sd40);
    chk("gap_vld", m_valid, 1);
    chk("gap_idx", idx_out, 3);
    chk("gap_max", max_out, 40);

    // Async reset mid-vector with a result still pending
    beat(16'sd50); beat(16'sd60);
    chk("pre_rst_vld", m_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_m_valid", m_valid, 0);
    chk("arst_s_ready", s_ready, 0);
    chk("arst_idx", idx_out, 0);
    chk("arst_max", max_out, 0);
    #1 reset = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    beat(16'sd4); beat(16'sd3);
    chk("post_rst_nv", m_valid, 0);
    beat(16'sd2); beat(16'sd1);
    chk("post_rst_vld", m_valid, 1);
    chk("post_rst_idx", idx_out, 0);
    chk("post_rst_max", max_out, 4);
    idle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
